// File: rtl/hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : hall_call_dispatcher
// Description : Two-car hall-call scheduler for a 4-floor elevator system.
//               It latches hall up/down presses into six call slots and
//               assigns each pending call to the car with the lowest
//               position/direction cost. Each car sees only its own calls.
//               A call clears when either car serves it. An assigned call
//               that waits AGE_LIMIT cycles moves to the other car.
// Ports       : clk                    - clock, rising edge
//               reset_n                - synchronous reset, active HIGH
//               hall_up[2:0]           - up presses, floors 1..3
//               hall_down[2:0]         - down presses, floors 2..4
//               carN_position[2:0]     - half-floor position (0 = floor 1)
//               carN_open              - door open
//               carN_direction[1:0]    - 00 stop, 01 up, 10 down
//               carN_up/carN_down[2:0] - calls assigned to car N
//               pending_up/down[2:0]   - hall lamps (slot not idle)
// Revision    : 1.0 - initial release
// ============================================================================
module hall_call_dispatcher #(
    parameter int AGE_LIMIT = 63
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] hall_up,
    input  logic [2:0] hall_down,
    input  logic [2:0] car0_position,
    input  logic [2:0] car1_position,
    input  logic       car0_open,
    input  logic       car1_open,
    input  logic [1:0] car0_direction,
    input  logic [1:0] car1_direction,
    output logic [2:0] car0_up,
    output logic [2:0] car1_up,
    output logic [2:0] car0_down,
    output logic [2:0] car1_down,
    output logic [2:0] pending_up,
    output logic [2:0] pending_down
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_AS0  = 2'd2,
        S_AS1  = 2'd3
    } slot_state_t;

    localparam logic [5:0] c_AGE_LIMIT = 6'(AGE_LIMIT);

    // Slots 0..2 are up[0..2], slots 3..5 are down[0..2].
    logic [5:0] w_press;
    logic [5:0] w_as0;
    logic [5:0] w_as1;
    logic [5:0] w_busy;

    assign w_press = {hall_down, hall_up};

    // The cost is {away, |pos - tgt|}. Bit 3 adds the +8 penalty for a car
    // that moves away from the target.
    function automatic logic [3:0] f_cost(input logic [2:0] pos,
                                          input logic [1:0] dir,
                                          input logic [2:0] tgt);
        logic [2:0] diff;
        logic       away;
        diff = (pos >= tgt) ? (pos - tgt) : (tgt - pos);
        away = ((dir == 2'b01) && (tgt < pos)) || ((dir == 2'b10) && (tgt > pos));
        return {away, diff};
    endfunction

    function automatic logic f_serves(input logic [2:0] pos,
                                      input logic       open,
                                      input logic [1:0] dir,
                                      input logic [2:0] tgt,
                                      input logic [1:0] cdir);
        return (pos == tgt) && open && ((dir == 2'b00) || (dir == cdir));
    endfunction

    for (genvar s = 0; s < 6; s++) begin : g_slot
        localparam logic [2:0] c_TGT  = (s < 3) ? 3'(2 * s) : 3'(2 * s - 4);
        localparam logic [1:0] c_CDIR = (s < 3) ? 2'b01 : 2'b10;

        slot_state_t r_state;
        slot_state_t w_state_nxt;
        logic [5:0]  r_age;
        logic [5:0]  w_age_nxt;
        logic        w_serve;
        logic [3:0]  w_cost0;
        logic [3:0]  w_cost1;

        assign w_serve = f_serves(car0_position, car0_open, car0_direction, c_TGT, c_CDIR)
                       | f_serves(car1_position, car1_open, car1_direction, c_TGT, c_CDIR);
        assign w_cost0 = f_cost(car0_position, car0_direction, c_TGT);
        assign w_cost1 = f_cost(car1_position, car1_direction, c_TGT);

        always_ff @(posedge clk) begin
            if (reset_n) begin
                r_state <= S_IDLE;
                r_age   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_age   <= w_age_nxt;
            end
        end

        // A serve takes priority over everything else. It clears the slot
        // even when the serving car is not the assigned one.
        always_comb begin
            w_state_nxt = r_state;
            w_age_nxt   = r_age;
            if (w_serve) begin
                w_state_nxt = S_IDLE;
                w_age_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press[s]) w_state_nxt = S_PEND;
                    end
                    S_PEND: begin
                        w_state_nxt = (w_cost0 <= w_cost1) ? S_AS0 : S_AS1;
                        w_age_nxt   = '0;
                    end
                    S_AS0: begin
                        if (r_age == c_AGE_LIMIT) begin
                            w_state_nxt = S_AS1;
                            w_age_nxt   = '0;
                        end else begin
                            w_age_nxt = r_age + 6'd1;
                        end
                    end
                    S_AS1: begin
                        if (r_age == c_AGE_LIMIT) begin
                            w_state_nxt = S_AS0;
                            w_age_nxt   = '0;
                        end else begin
                            w_age_nxt = r_age + 6'd1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_age_nxt   = '0;
                    end
                endcase
            end
        end

        assign w_as0[s]  = (r_state == S_AS0);
        assign w_as1[s]  = (r_state == S_AS1);
        assign w_busy[s] = (r_state != S_IDLE);
    end

    assign car0_up      = w_as0[2:0];
    assign car0_down    = w_as0[5:3];
    assign car1_up      = w_as1[2:0];
    assign car1_down    = w_as1[5:3];
    assign pending_up   = w_busy[2:0];
    assign pending_down = w_busy[5:3];

endmodule
`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_hall_call_dispatcher
// Description : Self-checking bench for hall_call_dispatcher. It runs the
//               directed scenarios first and then randomized traffic. A
//               behavioural call model checks every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hall_call_dispatcher;

    localparam int AGE_LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] hall_up = '0, hall_down = '0;
    logic [2:0] car0_position = '0, car1_position = '0;
    logic       car0_open = 1'b0, car1_open = 1'b0;
    logic [1:0] car0_direction = '0, car1_direction = '0;
    logic [2:0] car0_up, car1_up, car0_down, car1_down, pending_up, pending_down;

    hall_call_dispatcher #(.AGE_LIMIT(AGE_LIMIT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hall_up        (hall_up),
        .hall_down      (hall_down),
        .car0_position  (car0_position),
        .car1_position  (car1_position),
        .car0_open      (car0_open),
        .car1_open      (car1_open),
        .car0_direction (car0_direction),
        .car1_direction (car1_direction),
        .car0_up        (car0_up),
        .car1_up        (car1_up),
        .car0_down      (car0_down),
        .car1_down      (car1_down),
        .pending_up     (pending_up),
        .pending_down   (pending_down)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a call is either dark, lit but not yet given to a car,
    // or lit and owned by car 0/1 with a waiting time in cycles.
    bit lit   [6];
    int owner [6];   // -1 = no car yet
    int wait_c[6];

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int target_of(input int s);
        return (s < 3) ? 2 * s : 2 * (s - 3) + 2;
    endfunction

    function automatic int car_cost(input int pos, input int dir, input int tgt);
        int c;
        c = (pos > tgt) ? pos - tgt : tgt - pos;
        if ((dir == 1 && tgt < pos) || (dir == 2 && tgt > pos)) c += 8;
        return c;
    endfunction

    function automatic bit car_serves(input int pos, input bit open, input int dir,
                                      input int tgt, input int want_dir);
        return (pos == tgt) && open && (dir == 0 || dir == want_dir);
    endfunction

    task automatic model_step();
        logic [5:0] presses;
        presses = {hall_down, hall_up};
        for (int s = 0; s < 6; s++) begin
            int  tgt;
            int  want;
            bit  served;
            tgt  = target_of(s);
            want = (s < 3) ? 1 : 2;
            served = car_serves(int'(car0_position), car0_open, int'(car0_direction), tgt, want)
                   || car_serves(int'(car1_position), car1_open, int'(car1_direction), tgt, want);
            if (reset_n) begin
                lit[s] = 0; owner[s] = -1; wait_c[s] = 0;
            end else if (served) begin
                lit[s] = 0; owner[s] = -1; wait_c[s] = 0;
            end else if (lit[s] && owner[s] >= 0) begin
                if (wait_c[s] == AGE_LIMIT) begin
                    owner[s] = 1 - owner[s];
                    wait_c[s] = 0;
                end else begin
                    wait_c[s]++;
                end
            end else if (lit[s]) begin
                owner[s] = (car_cost(int'(car0_position), int'(car0_direction), tgt)
                         <= car_cost(int'(car1_position), int'(car1_direction), tgt)) ? 0 : 1;
                wait_c[s] = 0;
            end else if (presses[s]) begin
                lit[s] = 1;
            end
        end
    endtask

    // Advance one clock, update the model with the inputs sampled at that
    // edge, then compare every output just after the edge.
    task automatic cycle();
        logic [5:0] e0, e1, el;
        @(posedge clk);
        model_step();
        #1;
        for (int s = 0; s < 6; s++) begin
            e0[s] = lit[s] && owner[s] == 0;
            e1[s] = lit[s] && owner[s] == 1;
            el[s] = lit[s];
        end
        chk("car0_up",      car0_up,      e0[2:0]);
        chk("car0_down",    car0_down,    e0[5:3]);
        chk("car1_up",      car1_up,      e1[2:0]);
        chk("car1_down",    car1_down,    e1[5:3]);
        chk("pending_up",   pending_up,   el[2:0]);
        chk("pending_down", pending_down, el[5:3]);
    endtask

    task automatic set_cars(input logic [2:0] p0, input logic [1:0] d0, input logic o0,
                            input logic [2:0] p1, input logic [1:0] d1, input logic o1);
        car0_position = p0; car0_direction = d0; car0_open = o0;
        car1_position = p1; car1_direction = d1; car1_open = o1;
    endtask

    task automatic do_reset();
        hall_up = '0; hall_down = '0;
        reset_n = 1'b1;
        cycle();
        reset_n = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 6; s++) begin
            lit[s] = 0; owner[s] = -1; wait_c[s] = 0;
        end

        // Reset state
        set_cars(3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        do_reset();
        chk("rst_pending_up", pending_up, 3'b000);
        chk("rst_car0_up",    car0_up,    3'b000);

        // Up[0]: car0 at floor 4, car1 at floor 2 -> costs 6 vs 2 -> car1
        set_cars(3'd6, 2'd0, 1'b0, 3'd2, 2'd0, 1'b0);
        hall_up = 3'b001;
        cycle();
        hall_up = 3'b000;
        chk("s1_pending_up", pending_up, 3'b001);
        cycle();
        chk("s1_car1_up", car1_up, 3'b001);
        chk("s1_car0_up", car0_up, 3'b000);

        // Down[2]: cost tie -> car0, then car0 serves at floor 4
        do_reset();
        set_cars(3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        hall_down = 3'b100;
        cycle();
        hall_down = 3'b000;
        cycle();
        chk("s2_tie_car0_down", car0_down, 3'b100);
        set_cars(3'd6, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0);
        cycle();
        chk("s2_serve_car0_down", car0_down,    3'b000);
        chk("s2_serve_lamp",      pending_down, 3'b000);

        // Up[2] (target 4): car0 at 2 moving down costs 10, car1 at 6 costs 2
        do_reset();
        set_cars(3'd2, 2'd2, 1'b0, 3'd6, 2'd0, 1'b0);
        hall_up = 3'b100;
        cycle();
        hall_up = 3'b000;
        cycle();
        chk("s3_car1_up", car1_up, 3'b100);
        chk("s3_car0_up", car0_up, 3'b000);

        // Timeout: up[1] goes to car0 and moves to car1 four cycles later
        do_reset();
        set_cars(3'd2, 2'd0, 1'b0, 3'd6, 2'd0, 1'b0);
        hall_up = 3'b010;
        cycle();
        hall_up = 3'b000;
        cycle();
        chk("s4_assign_car0", car0_up, 3'b010);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("s4_hold_car0", car0_up,    3'b010);
            chk("s4_hold_car1", car1_up,    3'b000);
            chk("s4_hold_lamp", pending_up, 3'b010);
        end
        cycle();
        chk("s4_to_car0", car0_up,    3'b000);
        chk("s4_to_car1", car1_up,    3'b010);
        chk("s4_to_lamp", pending_up, 3'b010);

        // Level-held down[0] served by car0, then re-latches
        do_reset();
        set_cars(3'd2, 2'd2, 1'b0, 3'd6, 2'd0, 1'b0);
        hall_down = 3'b001;
        cycle();
        chk("s5_latch", pending_down, 3'b001);
        cycle();
        chk("s5_assign", car0_down, 3'b001);
        car0_open = 1'b1;
        cycle();
        chk("s5_served_lamp", pending_down, 3'b000);
        car0_open = 1'b0;
        cycle();
        chk("s5_relatch", pending_down, 3'b001);
        hall_down = 3'b000;
        cycle();
        chk("s5_reassign", car0_down, 3'b001);
        reset_n = 1'b1;
        cycle();
        reset_n = 1'b0;
        chk("s5_rst_car0_down", car0_down,    3'b000);
        chk("s5_rst_lamp",      pending_down, 3'b000);

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 199) == 0);
            hall_up   = 3'($urandom) & 3'($urandom) & 3'($urandom);
            hall_down = 3'($urandom) & 3'($urandom) & 3'($urandom);
            car0_position  = 3'($urandom_range(0, 6));
            car1_position  = 3'($urandom_range(0, 6));
            car0_direction = 2'($urandom_range(0, 2));
            car1_direction = 2'($urandom_range(0, 2));
            car0_open = ($urandom_range(0, 2) == 0);
            car1_open = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hall_call_dispatcher.md
# hall_call_dispatcher

Two-car hall-call scheduler for the 4-floor elevator system. It latches hall up/down button presses, assigns each pending call to one of two elevator cars by position/direction cost, and drives each car's `button_up`/`button_down` inputs with only its assigned calls. It clears each call when a car serves it, and reassigns calls that starve.

## Interface
- `AGE_LIMIT`, default 63: cycles an assigned call may wait unserved before it is reassigned to the other car (1..63).
- `clk` in 1: clock; all registers update on the rising edge.
- `reset_n` in 1: reset, synchronous, active-high (asserted = 1; the name follows codebase port naming).
- `hall_up` in 3: up-call presses; [0] floor 1, [1] floor 2, [2] floor 3. A 1-cycle pulse or a level.
- `hall_down` in 3: down-call presses; [0] floor 2, [1] floor 3, [2] floor 4.
- `car0_position`, `car1_position` in 3 each: car position, half-floor units; 000 = floor 1, 001 = between 1 and 2, …, 110 = floor 4.
- `car0_open`, `car1_open` in 1 each: door open.
- `car0_direction`, `car1_direction` in 2 each: 00 stop, 01 up, 10 down.
- `car0_up`, `car1_up` out 3 each: up calls assigned to that car; same bit map as `hall_up`.
- `car0_down`, `car1_down` out 3 each: down calls assigned to that car.
- `pending_up`, `pending_down` out 3 each: hall lamps; 1 while the call is in any non-IDLE state.

## Operation
- Six independent call slots: up[0..2] and down[0..2].
  - Target position: up[i] is 2i; down[i] is 2i+2.
  - Each slot holds a 2-bit state (IDLE, PEND, AS0, AS1) and a 6-bit age counter.
- IDLE → PEND when the press bit is 1 and the slot is not being served this cycle. Presses in any other state are ignored.
- PEND → AS0 or AS1 one cycle later.
  - Cost per car = |position − target| (0..6), plus 8 if the car moves away from the target: direction 01 with target < position, or 10 with target > position.
  - Lower cost wins; a tie goes to car0.
  - All PEND slots are assigned in the same cycle, independently of each other.
- AS0/AS1: the slot's bit is driven on that car's up/down output only; the other car's bit is 0. The age counter increments every cycle in AS state.
- Serve condition for a slot: either car has position == target, open == 1, and direction ∈ {00, call direction}. Up calls match direction 01, down calls match 10.
  - On serve, the slot → IDLE and the age counter clears.
  - A serve by the non-assigned car also clears the slot.
- Timeout: in AS0/AS1 with age == AGE_LIMIT and no serve, the slot moves directly to the opposite AS state and age resets to 0. There is no PEND detour and no cost evaluation.
- Priority per slot, highest first: reset, serve, timeout, assignment/age increment, press.
- A serve can also occur in PEND; the slot then → IDLE.
- Car outputs and lamps are decoded from the registered slot state, so outputs carry no combinational path from inputs.

## Timing
- Reset (reset_n = 1 at an edge): all slots IDLE, ages 0, all outputs 0 from the following cycle. Reset mid-operation drops every call with no partial state kept.
- Press sampled at edge t: `pending_*` = 1 after edge t; the car output bit = 1 after edge t+1. Latency is 2 cycles from press to car.
- Serve condition true at edge t: the car bit and lamp = 0 after edge t.
  - A press held high through edge t is ignored at edge t.
  - The press re-latches at edge t+1 if still high; a level-held button therefore re-registers one cycle after service.
- Cost inputs are sampled in the assignment cycle only; later car movement does not change the assignment except through timeout.
- Odd (between-floor) positions are valid cost inputs.
- A serve can never match an odd position, because targets are even.
- Timeout at edge t: the old car's bit drops and the new car's bit rises, both after edge t. Both are never high in the same cycle.

## Test plan
- Reset, then press up[0] with car0 at 110 stopped and car1 at 010 stopped.
  - Costs are 6 and 2, so the call goes to car1.
  - `pending_up` = 001 after 1 cycle; `car1_up` = 001 and `car0_up` = 000 after 2 cycles.
- Both cars at 000 stopped, press down[2] (target 110).
  - The tie goes to car0: `car0_down` = 100.
  - Then set car0 position 110, open = 1, direction 00: `car0_down` and `pending_down` return to 000 the next cycle.
- Car0 at 010 direction 10, car1 at 110 direction 00, press up[2] (target 100).
  - Car0 cost 2+8 = 10, car1 cost 2, so the call goes to car1.
- AGE_LIMIT = 3: assign up[1] to car0, never serve.
  - Exactly 4 cycles after the assignment edge, `car0_up[1]` falls and `car1_up[1]` rises on the same edge.
  - `pending_up[1]` stays 1 throughout.
- Hold `hall_down[0]` high while car0 serves it (position 010, open, direction 10).
  - The lamp clears for one cycle, then re-latches.
  - Separately, assert reset_n during an AS state: all outputs are 0 the next cycle.
